// File: rtl/lsu_split_access_if.sv
// lsu_split_access_if: request/response handshake channels plus the word-organised RAM port
// of the split-access load/store unit, bundled so the unit and its environment share one definition.
// Modports: slave = the LSU view (drives req_ready/rsp/mem strobes), master = core + RAM view.
interface lsu_split_access_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int WAW = ADDR_WIDTH - $clog2(NB);

  // request channel
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [2:0]            req_dtype_i;
  // response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  // RAM port
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [WAW-1:0]        mem_addr_o;
  logic [NB-1:0]         mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_dtype_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_dtype_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_split_access.sv
// lsu_split_access: any-alignment byte/half/word load/store onto a byte-enabled single-port RAM;
// word-crossing accesses become two beats. Latency store 1 (split 2), load 2 (split 3), error 1.
// Backpressure: one request in flight, req_ready only in IDLE, response held until rsp_ready.
// Ports: clk; reset_n (async, active low); bus = lsu_split_access_if.slave (req/rsp/mem channels).
// Option: LSU_MISALIGN_TRAP_EN makes addr mod size != 0 an error (no RAM access, never splits).
module lsu_split_access #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input logic               clk,
  input logic               reset_n,
  lsu_split_access_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LB  = $clog2(NB);
  localparam int WAW = ADDR_WIDTH - LB;
  localparam int SHW = LB + 3;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;
  state_t state_q, state_d;

  logic                  we_q, sext_q, err_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, buf_q, rdata_q;

  // request decode: size in bytes, sign extension, illegal type
  logic [2:0] req_size;
  logic       req_sext, req_bad;
  always_comb begin
    req_size = 3'd1;
    req_sext = 1'b0;
    req_bad  = 1'b0;
    case (bus.req_dtype_i)
      3'b000:  begin req_size = 3'd1; req_sext = 1'b1; end
      3'b001:  begin req_size = 3'd2; req_sext = 1'b1; end
      3'b010:  req_size = 3'd4;
      3'b011:  req_size = 3'd1;
      3'b100:  req_size = 3'd2;
      default: req_bad = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.req_addr_i[2:0] & (req_size - 3'd1)) != 3'd0) req_bad = 1'b1;
`endif
  end

  logic accept;
  assign accept = (state_q == IDLE) && bus.req_valid_i;

  // Access geometry. Everything is laid out over a two-word window: lanes
  // [NB-1:0] belong to beat0, lanes [2NB-1:NB] to beat1.
  logic [LB-1:0]           off;
  logic [SHW-1:0]          sh;
  logic                    split;
  logic [WAW-1:0]          word0;
  logic [NB-1:0]           smask;
  logic [DATA_WIDTH-1:0]   bmask;
  logic [2*NB-1:0]         be_wide;
  logic [2*DATA_WIDTH-1:0] wdata_wide;

  assign off    = addr_q[LB-1:0];
  assign sh     = {off, 3'b000};
  assign split  = ({1'b0, off} + (LB+1)'(size_q)) > (LB+1)'(NB);
  assign word0  = addr_q[ADDR_WIDTH-1:LB];
  assign smask  = NB'((5'd1 << size_q) - 5'd1);

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++) bmask[8*i +: 8] = {8{smask[i]}};
  end

  assign be_wide    = {{NB{1'b0}}, smask} << off;
  assign wdata_wide = {{DATA_WIDTH{1'b0}}, wdata_q & bmask} << sh;

  // Load merge: beat0 word sits in buf_q, the last beat arrives on mem_rdata_i in CAPT.
  logic [2*DATA_WIDTH-1:0] rd_pair;
  logic [DATA_WIDTH-1:0]   rd_val, rd_ext;
  logic                    rd_sign;
  always_comb begin
    rd_pair = split ? {bus.mem_rdata_i, buf_q} : {{DATA_WIDTH{1'b0}}, bus.mem_rdata_i};
    rd_val  = DATA_WIDTH'(rd_pair >> sh) & bmask;
    rd_sign = (size_q == 3'd1) ? rd_val[7] : rd_val[15];
    rd_ext  = (sext_q && rd_sign) ? (rd_val | ~bmask) : rd_val;
  end

  // next state and RAM strobes
  always_comb begin
    state_d         = state_q;
    bus.req_ready_o = 1'b0;
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_be_o    = '0;
    bus.mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = ACC0;
      end
      ACC0: begin
        if (err_q) begin
          state_d = RESP;  // illegal request: straight to response, RAM untouched
        end else begin
          bus.mem_en_o    = 1'b1;
          bus.mem_we_o    = we_q;
          bus.mem_addr_o  = word0;
          bus.mem_be_o    = be_wide[NB-1:0];
          bus.mem_wdata_o = wdata_wide[DATA_WIDTH-1:0];
          state_d         = split ? ACC1 : (we_q ? RESP : CAPT);
        end
      end
      ACC1: begin
        bus.mem_en_o    = 1'b1;
        bus.mem_we_o    = we_q;
        bus.mem_addr_o  = word0 + WAW'(1);  // top word wraps to word 0
        bus.mem_be_o    = be_wide[2*NB-1:NB];
        bus.mem_wdata_o = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d         = we_q ? RESP : CAPT;
      end
      CAPT: state_d = RESP;
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_err_o   = (state_q == RESP) && err_q;
  assign bus.rsp_rdata_o = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 3'd1;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        size_q  <= req_size;
        sext_q  <= req_sext;
        err_q   <= req_bad;
        rdata_q <= '0;  // stores and errors answer with zero data
      end
      if (state_q == ACC1) buf_q <= bus.mem_rdata_i;  // beat0 read data
      if (state_q == CAPT && !we_q) rdata_q <= rd_ext;
    end
  end
endmodule

// File: tb/tb_lsu_split_access.sv
// tb_lsu_split_access: directed scenarios then random traffic against a byte-array memory model.
// The bench also plays the RAM (one-cycle read latency) and logs every RAM strobe.
module tb_lsu_split_access;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_split_access_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  lsu_split_access #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // RAM device seen by the DUT
  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E3779B1) + 32'h01234567;
  endfunction

  logic [31:0] ram [1024];
  logic [31:0] rd_q;
  logic ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int w = 0; w < 1024; w++) ram[w] <= init_word(w);
      ram_ready <= 1'b1;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        for (int l = 0; l < 4; l++)
          if (bus.mem_be_o[l]) ram[bus.mem_addr_o][8*l +: 8] <= bus.mem_wdata_o[8*l +: 8];
      end else begin
        rd_q <= ram[bus.mem_addr_o];
      end
    end
  end
  assign bus.mem_rdata_i = rd_q;

  // strobe log
  logic [9:0] mon_addr[$];
  logic [3:0] mon_be[$];
  logic       mon_we[$];
  always @(negedge clk) begin
    if (bus.mem_en_o === 1'b1) begin
      mon_addr.push_back(bus.mem_addr_o);
      mon_be.push_back(bus.mem_be_o);
      mon_we.push_back(bus.mem_we_o);
    end
  end

  // reference memory, one entry per byte address
  logic [7:0] mdl [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [2:0] dt, input int hold, output logic [31:0] rdata);
    int size, lat, np, start, off;
    bit sext, bad, split;
    logic [31:0] exp_rd, mask;
    logic [3:0] ebe [2];
    logic [9:0] ewa [2];
    logic exp_err;
    // reference behaviour from the access rules
    size = 1; sext = 0; bad = 0;
    case (dt)
      3'd0: begin size = 1; sext = 1; end
      3'd1: begin size = 2; sext = 1; end
      3'd2: size = 4;
      3'd3: size = 1;
      3'd4: size = 2;
      default: bad = 1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (addr % size != 0) bad = 1;
`endif
    off = addr % 4;
    split = !bad && (off + size > 4);
    exp_err = bad;
    np = bad ? 0 : (split ? 2 : 1);
    ebe[0] = 4'b0; ebe[1] = 4'b0;
    ewa[0] = addr[11:2];
    ewa[1] = addr[11:2] + 10'd1;
    for (int i = 0; i < size; i++) ebe[(off + i) >= 4 ? 1 : 0][(addr + i) % 4] = 1'b1;
    exp_rd = 32'h0;
    mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (!bad && !we) begin
      for (int i = 0; i < size; i++) exp_rd |= 32'(mdl[(addr + i) % 4096]) << (8 * i);
      if (sext && exp_rd[8*size-1]) exp_rd |= ~mask;
    end
    if (!bad && we)
      for (int i = 0; i < size; i++) mdl[(addr + i) % 4096] = wd[8*i +: 8];

    @(negedge clk);
    chk("req_ready_idle", bus.req_ready_o, 1);
    start = mon_addr.size();
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = addr;
    bus.req_wdata_i = wd; bus.req_dtype_i = dt;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 0;
    while (bus.rsp_valid_o !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, bad ? 1 : ((we ? 1 : 2) + (split ? 1 : 0)));
    rdata = bus.rsp_rdata_o;
    chk("rsp_rdata", bus.rsp_rdata_o, exp_rd);
    chk("rsp_err", bus.rsp_err_o, exp_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.rsp_valid_o, 1);
      chk("hold_rdata", bus.rsp_rdata_o, exp_rd);
      chk("hold_err", bus.rsp_err_o, exp_err);
      chk("hold_req_ready", bus.req_ready_o, 0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk("rsp_dropped", bus.rsp_valid_o, 0);
    chk("strobe_count", mon_addr.size() - start, np);
    for (int k = 0; k < np && start + k < mon_addr.size(); k++) begin
      chk("strobe_addr", mon_addr[start+k], ewa[k]);
      chk("strobe_be", mon_be[start+k], ebe[k]);
      chk("strobe_we", mon_we[start+k], we);
    end
  endtask

  initial begin
    logic [31:0] rd, w;
    int r;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0; bus.req_dtype_i = 3'b0; bus.rsp_ready_i = 1'b0;
    for (int wi = 0; wi < 1024; wi++) begin
      w = init_word(wi);
      for (int l = 0; l < 4; l++) mdl[4*wi + l] = w[8*l +: 8];
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_err", bus.rsp_err_o, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_be", bus.mem_be_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    reset_n = 1'b1;

    // aligned word store/load
    xact(1, 12'h010, 32'hDEADBEEF, 3'b010, 0, rd);
    xact(0, 12'h010, 32'h0, 3'b010, 0, rd);
    chk("t1_ld_w", rd, 32'hDEADBEEF);

    // byte store, signed/unsigned byte loads, merged word
    xact(1, 12'h013, 32'h00000080, 3'b000, 0, rd);
    xact(0, 12'h013, 32'h0, 3'b000, 0, rd);
    chk("t2_ld_b", rd, 32'hFFFFFF80);
    xact(0, 12'h013, 32'h0, 3'b011, 1, rd);
    chk("t2_ld_bu", rd, 32'h00000080);
    xact(0, 12'h010, 32'h0, 3'b010, 0, rd);
    chk("t2_ld_w", rd, 32'h80ADBEEF);

    // word crossing a word boundary, and a half crossing the top of memory
    xact(1, 12'h016, 32'h11223344, 3'b010, 0, rd);
    xact(0, 12'h016, 32'h0, 3'b010, 0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("t3_ld_w_split", rd, 32'h11223344);
`endif
    xact(1, 12'hFFF, 32'h0000ABCD, 3'b001, 0, rd);
    xact(0, 12'hFFF, 32'h0, 3'b100, 0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("t4_ld_hu_wrap", rd, 32'h0000ABCD);
`endif
    xact(0, 12'hFFF, 32'h0, 3'b001, 0, rd);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("t4_ld_h_wrap", rd, 32'hFFFFABCD);
`endif

    // illegal dtype with a stalled response
    xact(0, 12'h020, 32'h0, 3'b111, 5, rd);

`ifndef LSU_MISALIGN_TRAP_EN
    // reset during the second beat of a split store
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 12'hFFF;
    bus.req_wdata_i = 32'h000055AB; bus.req_dtype_i = 3'b001;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("t6_acc1_en", bus.mem_en_o, 1);
    chk("t6_acc1_addr", bus.mem_addr_o, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_mem_en", bus.mem_en_o, 0);
    chk("t6_mem_we", bus.mem_we_o, 0);
    chk("t6_mem_addr", bus.mem_addr_o, 0);
    chk("t6_mem_be", bus.mem_be_o, 0);
    chk("t6_mem_wdata", bus.mem_wdata_o, 0);
    chk("t6_rsp_valid", bus.rsp_valid_o, 0);
    chk("t6_req_ready", bus.req_ready_o, 1);
    mdl[12'hFFF] = 8'hAB;  // only beat0 landed
    @(negedge clk);
    reset_n = 1'b1;
    xact(0, 12'hFFF, 32'h0, 3'b000, 0, rd);
    chk("t6_ld_b", rd, 32'hFFFFFFAB);
    xact(0, 12'h000, 32'h0, 3'b011, 0, rd);
`endif

    // random traffic
    for (int n = 0; n < 200; n++) begin
      logic [11:0] a;
      logic [2:0] dt;
      a = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) a = 12'hFFC + 12'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      dt = (r < 8) ? 3'(r % 5) : 3'(5 + r % 3);
      xact(1'($urandom_range(0, 1)), a, $urandom, dt, $urandom_range(0, 2), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
